silent_interpolator: RTL and testbench

Per-transducer slew limiter that consumes the silencer step stream and emits the current drive values. For each transducer it moves the current intensity and phase toward the burst's target by at most the supplied update rate. It sits directly downstream of the silencer step calculator and upstream of the PWM/modulation stage. State is held across bursts, one entry per transducer.

---
 rtl/silent_pkg.sv | 22 ++
 rtl/silent_step_limiter.sv | 39 +++
 rtl/silent_interpolator.sv | 112 +++++++++++
 tb/tb_silent_interpolator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/silent_pkg.sv
// Shared widths, constants and stage-1 payload for the silencer interpolator.
package silent_pkg;

  localparam int INTENSITY_W = 16;
  localparam int PHASE_W     = 16;
  localparam int RATE_W      = 16;

  // Phase distance at or above this is taken the short way backward.
  localparam logic [PHASE_W-1:0] PHASE_HALF = 16'h8000;

  // Everything stage 2 needs for one transducer beat.
  typedef struct packed {
    logic [INTENSITY_W-1:0] tgt_i;
    logic [PHASE_W-1:0]     tgt_p;
    logic [RATE_W-1:0]      rate_i;
    logic [RATE_W-1:0]      rate_p;
    logic [INTENSITY_W-1:0] cur_i;
    logic [PHASE_W-1:0]     cur_p;
    logic                   bypass;
  } s1_t;

endpackage

// File: rtl/silent_step_limiter.sv
// Moves cur toward tgt by at most rate. WRAP=1 treats the value as a
// modulo-2^16 angle and takes the shorter way round (half-turn goes backward).
module silent_step_limiter
  import silent_pkg::*;
#(
  parameter bit WRAP = 1'b0
) (
  input  logic [RATE_W-1:0] cur,
  input  logic [RATE_W-1:0] tgt,
  input  logic [RATE_W-1:0] rate,
  input  logic              bypass,
  output logic [RATE_W-1:0] next
);

  logic              w_fwd;
  logic [RATE_W-1:0] w_diff;
  logic [RATE_W-1:0] w_dist;
  logic [RATE_W-1:0] w_step;

  assign w_diff = tgt - cur;

  generate
    if (WRAP) begin : g_wrap
      // Zero distance counts as backward with dist 0, which holds the value.
      assign w_fwd  = (w_diff != '0) && (w_diff < PHASE_HALF);
      assign w_dist = w_fwd ? w_diff : (RATE_W'(0) - w_diff);
    end else begin : g_lin
      assign w_fwd  = (tgt > cur);
      assign w_dist = w_fwd ? w_diff : (cur - tgt);
    end
  endgenerate

  // Clamp the step to the remaining distance so we never overshoot.
  always_comb begin
    w_step = (rate < w_dist) ? rate : w_dist;
    next   = bypass ? tgt : (w_fwd ? (cur + w_step) : (cur - w_step));
  end

endmodule

// File: rtl/silent_interpolator.sv
// Per-transducer slew limiter: two-stage pipeline, state held across bursts.
module silent_interpolator
  import silent_pkg::*;
#(
  parameter int DEPTH = 249
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   DIN_VALID,
  input  logic [INTENSITY_W-1:0] INTENSITY_IN,
  input  logic [PHASE_W-1:0]     PHASE_IN,
  input  logic [RATE_W-1:0]      UPDATE_RATE_INTENSITY,
  input  logic [RATE_W-1:0]      UPDATE_RATE_PHASE,
  input  logic                   BYPASS,
  output logic [INTENSITY_W-1:0] INTENSITY_OUT,
  output logic [PHASE_W-1:0]     PHASE_OUT,
  output logic                   DOUT_VALID
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_s1_idx;
  s1_t                    r_s1;
  logic [1:0]             r_vld_pipe;
  logic [DEPTH-1:0]       r_init;
  logic [INTENSITY_W-1:0] r_cur_i [DEPTH];
  logic [PHASE_W-1:0]     r_cur_p [DEPTH];
  logic [INTENSITY_W-1:0] r_int_out;
  logic [PHASE_W-1:0]     r_ph_out;

  logic [INTENSITY_W-1:0] w_rd_i;
  logic [PHASE_W-1:0]     w_rd_p;
  logic [INTENSITY_W-1:0] w_next_i;
  logic [PHASE_W-1:0]     w_next_p;

  // Entries never written since reset read as zero.
  always_comb begin
    w_rd_i = r_init[r_idx] ? r_cur_i[r_idx] : '0;
    w_rd_p = r_init[r_idx] ? r_cur_p[r_idx] : '0;
  end

  // Transducer index: advances per accepted beat, wraps at DEPTH-1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         r_idx <= '0;
    else if (DIN_VALID) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
  end

  // Stage 1: capture the beat and the current state of its entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_s1_idx   <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], DIN_VALID};
      if (DIN_VALID) begin
        r_s1.tgt_i  <= INTENSITY_IN;
        r_s1.tgt_p  <= PHASE_IN;
        r_s1.rate_i <= UPDATE_RATE_INTENSITY;
        r_s1.rate_p <= UPDATE_RATE_PHASE;
        r_s1.cur_i  <= w_rd_i;
        r_s1.cur_p  <= w_rd_p;
        r_s1.bypass <= BYPASS;
        r_s1_idx    <= r_idx;
      end
    end
  end

  silent_step_limiter #(.WRAP(1'b0)) u_lim_i (
    .cur    (r_s1.cur_i),
    .tgt    (r_s1.tgt_i),
    .rate   (r_s1.rate_i),
    .bypass (r_s1.bypass),
    .next   (w_next_i)
  );

  silent_step_limiter #(.WRAP(1'b1)) u_lim_p (
    .cur    (r_s1.cur_p),
    .tgt    (r_s1.tgt_p),
    .rate   (r_s1.rate_p),
    .bypass (r_s1.bypass),
    .next   (w_next_p)
  );

  // Stage 2: register the limited values onto the outputs; hold when idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_int_out <= '0;
      r_ph_out  <= '0;
      r_init    <= '0;
    end else if (r_vld_pipe[0]) begin
      r_int_out          <= w_next_i;
      r_ph_out           <= w_next_p;
      r_init[r_s1_idx]   <= 1'b1;
    end
  end

  // Stage 2 write-back of the state memory (contents are don't-care until init).
  always_ff @(posedge CLK) begin
    if (r_vld_pipe[0]) begin
      r_cur_i[r_s1_idx] <= w_next_i;
      r_cur_p[r_s1_idx] <= w_next_p;
    end
  end

  assign INTENSITY_OUT = r_int_out;
  assign PHASE_OUT     = r_ph_out;
  assign DOUT_VALID    = r_vld_pipe[1];

endmodule

// File: tb/tb_silent_interpolator.sv
// Randomized and directed bench for silent_interpolator with an arithmetic model.
module tb_silent_interpolator;

  localparam int DEPTH = 249;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        DIN_VALID = 1'b0;
  logic [15:0] INTENSITY_IN = '0;
  logic [15:0] PHASE_IN = '0;
  logic [15:0] UPDATE_RATE_INTENSITY = '0;
  logic [15:0] UPDATE_RATE_PHASE = '0;
  logic        BYPASS = 1'b0;
  logic [15:0] INTENSITY_OUT;
  logic [15:0] PHASE_OUT;
  logic        DOUT_VALID;

  silent_interpolator #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN_VALID(DIN_VALID),
    .INTENSITY_IN(INTENSITY_IN), .PHASE_IN(PHASE_IN),
    .UPDATE_RATE_INTENSITY(UPDATE_RATE_INTENSITY),
    .UPDATE_RATE_PHASE(UPDATE_RATE_PHASE), .BYPASS(BYPASS),
    .INTENSITY_OUT(INTENSITY_OUT), .PHASE_OUT(PHASE_OUT),
    .DOUT_VALID(DOUT_VALID)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model state: current value per transducer, index, and two-beat delay line.
  int m_ci [DEPTH];
  int m_cp [DEPTH];
  int m_idx = 0;
  int m_last_idx = 0;
  bit p_vld = 0; int p_i = 0; int p_p = 0;
  bit e_vld = 0; int e_i = 0; int e_p = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int step_int(input int c, input int t, input int r);
    if (t > c) return c + imin(r, t - c);
    if (t < c) return c - imin(r, c - t);
    return c;
  endfunction

  function automatic int step_ph(input int c, input int t, input int r);
    int d;
    d = (t - c) & 16'hFFFF;
    if (d == 0) return c;
    if (d < 32768) return (c + imin(r, d)) & 16'hFFFF;
    return (c - imin(r, 65536 - d)) & 16'hFFFF;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) begin m_ci[k] = 0; m_cp[k] = 0; end
    m_idx = 0;
    p_vld = 0; p_i = 0; p_p = 0;
    e_vld = 0; e_i = 0; e_p = 0;
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge CLK) begin
    if (RST_N) begin
      e_vld = p_vld;
      if (p_vld) begin e_i = p_i; e_p = p_p; end
      p_vld = DIN_VALID;
      if (DIN_VALID) begin
        if (BYPASS) begin
          p_i = int'(INTENSITY_IN); p_p = int'(PHASE_IN);
        end else begin
          p_i = step_int(m_ci[m_idx], int'(INTENSITY_IN), int'(UPDATE_RATE_INTENSITY));
          p_p = step_ph(m_cp[m_idx], int'(PHASE_IN), int'(UPDATE_RATE_PHASE));
        end
        m_ci[m_idx] = p_i;
        m_cp[m_idx] = p_p;
        m_last_idx = m_idx;
        m_idx = (m_idx + 1) % DEPTH;
      end
    end
  end

  // Compare on the falling edge, well away from the sampling edge.
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("dout_valid", int'(DOUT_VALID), int'(e_vld));
      chk("intensity",  int'(INTENSITY_OUT), e_i);
      chk("phase",      int'(PHASE_OUT), e_p);
    end
  end

  task automatic beat(input int ti, input int tp, input int ri, input int rp, input bit byp);
    DIN_VALID = 1'b1;
    INTENSITY_IN = 16'(ti); PHASE_IN = 16'(tp);
    UPDATE_RATE_INTENSITY = 16'(ri); UPDATE_RATE_PHASE = 16'(rp);
    BYPASS = byp;
    @(posedge CLK); #1;
    DIN_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    DIN_VALID = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // One full burst; optional 3-cycle gap before entry gap_at; rnd randomizes each beat.
  task automatic burst(input int ti, input int tp, input int ri, input int rp,
                       input bit byp, input int gap_at, input bit rnd);
    for (int k = 0; k < DEPTH; k++) begin
      if (k == gap_at) begin
        idle(3);
        chk("model_idx_at_gap", m_idx, gap_at);
      end
      if (rnd) begin
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        beat($urandom_range(0, 65535), $urandom_range(0, 65535),
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 65535),
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 65535),
             ($urandom_range(0, 7) == 0));
      end else begin
        beat(ti, tp, ri, rp, byp);
      end
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    DIN_VALID = 1'b0;
    model_clear();
    #1;
    chk("rst_dout_valid", int'(DOUT_VALID), 0);
    chk("rst_intensity",  int'(INTENSITY_OUT), 0);
    chk("rst_phase",      int'(PHASE_OUT), 0);
    @(posedge CLK); @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  initial begin
    model_clear();
    #12;
    do_reset();

    // Ramp-up: 0 -> 0x1000 in steps of 0x100.
    for (int b = 1; b <= 17; b++) begin
      burst(16'h1000, 0, 16'h0100, 0, 1'b0, -1, 1'b0);
      if (b == 1)  begin chk("ramp_b1_e0", m_ci[0], 16'h0100); chk("ramp_b1_last", m_ci[DEPTH-1], 16'h0100); end
      if (b == 16) chk("ramp_b16", m_ci[5], 16'h1000);
      if (b == 17) chk("ramp_b17_hold", m_ci[DEPTH-1], 16'h1000);
    end

    // Preload intensity 0x0050 and phase 0xFF00 via bypass.
    burst(16'h0050, 16'hFF00, 0, 0, 1'b1, -1, 1'b0);
    chk("preload_p", m_cp[7], 16'hFF00);
    burst(0, 16'h0100, 16'h0100, 16'h0080, 1'b0, -1, 1'b0);
    chk("int_down", m_ci[3], 0);
    chk("ph_fwd1", m_cp[3], 16'hFF80);
    burst(0, 16'h0100, 16'h0100, 16'h0080, 1'b0, -1, 1'b0);
    chk("ph_fwd2", m_cp[3], 16'h0000);
    chk("int_stay0", m_ci[3], 0);
    burst(0, 16'h0100, 16'h0100, 16'h0080, 1'b0, -1, 1'b0);
    chk("ph_fwd3", m_cp[3], 16'h0080);
    burst(0, 16'h0100, 16'h0100, 16'h0080, 1'b0, -1, 1'b0);
    chk("ph_fwd4", m_cp[3], 16'h0100);
    burst(0, 16'h0100, 16'h0100, 16'h0080, 1'b0, -1, 1'b0);
    chk("ph_hold", m_cp[3], 16'h0100);

    // Backward phase, then bypass snap; half-turn resolves backward.
    burst(0, 16'hF000, 0, 16'h0800, 1'b0, -1, 1'b0);
    chk("ph_back", m_cp[10], 16'hF900);
    burst(0, 16'hF000, 0, 16'h0800, 1'b1, -1, 1'b0);
    chk("ph_bypass", m_cp[10], 16'hF000);
    burst(0, 16'h7000, 0, 16'h0100, 1'b0, -1, 1'b0);
    chk("ph_half_back", m_cp[10], 16'hEF00);

    // Gap of 3 idle cycles before entry 100; burst ends on entry 248 then wraps.
    burst(16'h2000, 16'h1234, 16'h0400, 16'h0400, 1'b0, 100, 1'b0);
    chk("last_idx", m_last_idx, DEPTH - 1);
    chk("wrap_idx", m_idx, 0);

    // Randomized bursts with random gaps, rates and bypass.
    for (int b = 0; b < 6; b++) burst(0, 0, 0, 0, 1'b0, -1, 1'b1);

    // Reset mid-burst at entry 50, then restart from zero state.
    for (int k = 0; k < 50; k++) beat(16'h3000, 16'h4000, 16'h0100, 16'h0100, 1'b0);
    do_reset();
    burst(16'h1000, 16'h8000, 16'h0100, 16'h0100, 1'b0, -1, 1'b0);
    chk("post_rst_i", m_ci[0], 16'h0100);
    chk("post_rst_p", m_cp[0], 16'hFF00);
    chk("post_rst_i_last", m_ci[DEPTH-1], 16'h0100);
    for (int b = 0; b < 3; b++) burst(0, 0, 0, 0, 1'b0, -1, 1'b1);

    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
